// File: rtl/mem_access_stage.sv
// Memory-access stage: doubleword loads/stores over a ready-handshaked port,
// upstream stall while an access is in flight, registered write-back packet with fault reporting.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ExValid,
  input  logic [63:0] ALUResult,
  input  logic [63:0] WriteData,
  input  logic [4:0]  RdOut,
  input  logic        MemReadOut,
  input  logic        MemtoRegOut,
  input  logic        MemWriteOut,
  input  logic        RegWriteOut,
  output logic        Stall,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [63:0] DMemAddr,
  output logic [63:0] DMemWData,
  input  logic        DMemReady,
  input  logic [63:0] DMemRData,
  output logic        WBValid,
  output logic [63:0] WBData,
  output logic [4:0]  WBRd,
  output logic        WBRegWrite,
  output logic        FaultValid,
  output logic [1:0]  FaultCode
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_MIS  = 2'b01;
  localparam logic [1:0] FAULT_TMO  = 2'b10;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       rd_r;
  logic             mem_to_reg_r;
  logic             reg_write_r;

  logic memop_s;
  logic aligned_s;
  logic alu_pkt_s;
  logic misal_s;
  logic accept_s;
  logic done_s;
  logic tmo_s;

  assign memop_s   = MemReadOut | MemWriteOut;
  assign aligned_s = (ALUResult[2:0] == 3'b000);

  // Next-state decode, stall and one-hot event strobes for the register blocks.
  always_comb begin
    state_nxt_s = state_r;
    Stall       = 1'b0;
    alu_pkt_s   = 1'b0;
    misal_s     = 1'b0;
    accept_s    = 1'b0;
    done_s      = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (ExValid) begin
          if (!memop_s) begin
            alu_pkt_s = 1'b1;
          end else if (!aligned_s) begin
            misal_s = 1'b1;
          end else begin
            accept_s    = 1'b1;
            Stall       = 1'b1;
            state_nxt_s = ACCESS;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (DMemReady) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (cnt_r >= CNT_LAST) begin
          tmo_s       = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          Stall = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Timeout counter: cleared on accept, saturating count of ACCESS cycles without ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      cnt_r <= CNT_ZERO;
    end else if (state_r == ACCESS && !DMemReady && cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Memory request port and the context of the access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DMemReq      <= 1'b0;
      DMemWe       <= 1'b0;
      DMemAddr     <= 64'h0;
      DMemWData    <= 64'h0;
      rd_r         <= 5'd0;
      mem_to_reg_r <= 1'b0;
      reg_write_r  <= 1'b0;
    end else if (accept_s) begin
      DMemReq      <= 1'b1;
      DMemWe       <= MemWriteOut;
      DMemAddr     <= ALUResult;
      DMemWData    <= WriteData;
      rd_r         <= RdOut;
      mem_to_reg_r <= MemtoRegOut;
      reg_write_r  <= RegWriteOut;
    end else if (done_s || tmo_s) begin
      DMemReq <= 1'b0;
      DMemWe  <= 1'b0;
    end else begin
      DMemReq <= DMemReq;
      DMemWe  <= DMemWe;
    end
  end

  // Write-back packet: strobes pulse for one cycle, payload holds until the next packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WBValid    <= 1'b0;
      WBData     <= 64'h0;
      WBRd       <= 5'd0;
      WBRegWrite <= 1'b0;
      FaultValid <= 1'b0;
      FaultCode  <= FAULT_NONE;
    end else begin
      WBValid    <= alu_pkt_s | misal_s | done_s | tmo_s;
      FaultValid <= misal_s | tmo_s;
      if (alu_pkt_s) begin
        WBData     <= ALUResult;
        WBRd       <= RdOut;
        WBRegWrite <= RegWriteOut;
        FaultCode  <= FAULT_NONE;
      end else if (misal_s) begin
        WBData     <= ALUResult;
        WBRd       <= RdOut;
        WBRegWrite <= 1'b0;
        FaultCode  <= FAULT_MIS;
      end else if (done_s) begin
        WBData     <= mem_to_reg_r ? DMemRData : DMemAddr;
        WBRd       <= rd_r;
        WBRegWrite <= reg_write_r;
        FaultCode  <= FAULT_NONE;
      end else if (tmo_s) begin
        WBData     <= DMemAddr;
        WBRd       <= rd_r;
        WBRegWrite <= 1'b0;
        FaultCode  <= FAULT_TMO;
      end else begin
        FaultCode  <= FAULT_NONE;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4): ALU op, load/store, misalignment,
// timeout, late/idle ready and asynchronous reset mid-access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ExValid;
  logic [63:0] ALUResult;
  logic [63:0] WriteData;
  logic [4:0]  RdOut;
  logic        MemReadOut, MemtoRegOut, MemWriteOut, RegWriteOut;
  logic        Stall, DMemReq, DMemWe;
  logic [63:0] DMemAddr, DMemWData;
  logic        DMemReady;
  logic [63:0] DMemRData;
  logic        WBValid;
  logic [63:0] WBData;
  logic [4:0]  WBRd;
  logic        WBRegWrite, FaultValid;
  logic [1:0]  FaultCode;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ExValid(ExValid), .ALUResult(ALUResult),
    .WriteData(WriteData), .RdOut(RdOut), .MemReadOut(MemReadOut),
    .MemtoRegOut(MemtoRegOut), .MemWriteOut(MemWriteOut), .RegWriteOut(RegWriteOut),
    .Stall(Stall), .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .DMemReady(DMemReady), .DMemRData(DMemRData),
    .WBValid(WBValid), .WBData(WBData), .WBRd(WBRd), .WBRegWrite(WBRegWrite),
    .FaultValid(FaultValid), .FaultCode(FaultCode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [63:0] alu, input logic [63:0] wd,
                    input logic [4:0] rd, input logic mr, input logic m2r,
                    input logic mw, input logic rw);
    ExValid = v; ALUResult = alu; WriteData = wd; RdOut = rd;
    MemReadOut = mr; MemtoRegOut = m2r; MemWriteOut = mw; RegWriteOut = rw;
  endtask

  initial begin
    rst_n = 1'b0;
    ex(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    DMemReady = 1'b0;
    DMemRData = 64'h0;
    tick();
    tick();
    // reset state
    chk("rst_req",   DMemReq,    1'b0);
    chk("rst_we",    DMemWe,     1'b0);
    chk("rst_addr",  DMemAddr,   64'h0);
    chk("rst_wdata", DMemWData,  64'h0);
    chk("rst_wbv",   WBValid,    1'b0);
    chk("rst_wbd",   WBData,     64'h0);
    chk("rst_wbrd",  WBRd,       5'd0);
    chk("rst_wbrw",  WBRegWrite, 1'b0);
    chk("rst_fv",    FaultValid, 1'b0);
    chk("rst_fc",    FaultCode,  2'b00);
    chk("rst_stall", Stall,      1'b0);
    rst_n = 1'b1;

    // ALU op
    tick();
    ex(1'b1, 64'h1234, 64'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("alu_stall", Stall, 1'b0);
    tick();
    ex(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu_wbv",   WBValid,    1'b1);
    chk("alu_wbd",   WBData,     64'h1234);
    chk("alu_wbrd",  WBRd,       5'd5);
    chk("alu_wbrw",  WBRegWrite, 1'b1);
    chk("alu_fv",    FaultValid, 1'b0);
    chk("alu_req",   DMemReq,    1'b0);
    tick();
    chk("alu_strobe", WBValid, 1'b0);
    chk("alu_hold",   WBData,  64'h1234);

    // Load, ready in third ACCESS cycle
    ex(1'b1, 64'h100, 64'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("ld_stall_acc", Stall, 1'b1);
    chk("ld_req0", DMemReq, 1'b0);
    tick();
    chk("ld_req1",   DMemReq,  1'b1);
    chk("ld_addr",   DMemAddr, 64'h100);
    chk("ld_we",     DMemWe,   1'b0);
    chk("ld_stall1", Stall,    1'b1);
    tick();
    chk("ld_req2",   DMemReq, 1'b1);
    chk("ld_stall2", Stall,   1'b1);
    tick();
    DMemReady = 1'b1;
    DMemRData = 64'hDEADBEEF;
    #1 chk("ld_req3", DMemReq, 1'b1);
    chk("ld_stall3", Stall, 1'b0);
    tick();
    DMemReady = 1'b0;
    DMemRData = 64'h0;
    ex(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_wbv",   WBValid,    1'b1);
    chk("ld_wbd",   WBData,     64'hDEADBEEF);
    chk("ld_wbrd",  WBRd,       5'd7);
    chk("ld_wbrw",  WBRegWrite, 1'b1);
    chk("ld_fv",    FaultValid, 1'b0);
    chk("ld_reqoff", DMemReq,   1'b0);

    // Store, immediate ready
    tick();
    ex(1'b1, 64'h08, 64'hAA, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("st_stall_acc", Stall, 1'b1);
    tick();
    ex(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    DMemReady = 1'b1;
    chk("st_req",   DMemReq,   1'b1);
    chk("st_we",    DMemWe,    1'b1);
    chk("st_wdata", DMemWData, 64'hAA);
    chk("st_addr",  DMemAddr,  64'h08);
    #1 chk("st_stall", Stall, 1'b0);
    tick();
    DMemReady = 1'b0;
    chk("st_reqoff", DMemReq,    1'b0);
    chk("st_weoff",  DMemWe,     1'b0);
    chk("st_wbv",    WBValid,    1'b1);
    chk("st_wbrw",   WBRegWrite, 1'b0);
    chk("st_wbd",    WBData,     64'h08);

    // Misaligned load, then ready in IDLE is ignored
    ex(1'b1, 64'h104, 64'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("mis_stall", Stall, 1'b0);
    tick();
    ex(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    DMemReady = 1'b1;
    chk("mis_req",  DMemReq,    1'b0);
    chk("mis_wbv",  WBValid,    1'b1);
    chk("mis_fv",   FaultValid, 1'b1);
    chk("mis_fc",   FaultCode,  2'b01);
    chk("mis_wbrw", WBRegWrite, 1'b0);
    chk("mis_wbrd", WBRd,       5'd3);
    tick();
    DMemReady = 1'b0;
    chk("idle_rdy_wbv", WBValid,    1'b0);
    chk("idle_rdy_req", DMemReq,    1'b0);
    chk("idle_rdy_fv",  FaultValid, 1'b0);
    chk("idle_rdy_fc",  FaultCode,  2'b00);

    // Timeout (TIMEOUT=4): request high 4 cycles, stall drops in the last
    ex(1'b1, 64'h200, 64'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("tmo_stall_acc", Stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_req",   DMemReq, 1'b1);
      chk("tmo_stall", Stall,   1'b1);
    end
    tick();
    chk("tmo_req_last",   DMemReq, 1'b1);
    chk("tmo_stall_last", Stall,   1'b0);
    tick();
    ex(1'b1, 64'h55, 64'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    DMemReady = 1'b1;
    chk("tmo_reqoff", DMemReq,    1'b0);
    chk("tmo_wbv",    WBValid,    1'b1);
    chk("tmo_fv",     FaultValid, 1'b1);
    chk("tmo_fc",     FaultCode,  2'b10);
    chk("tmo_wbrw",   WBRegWrite, 1'b0);
    chk("tmo_wbrd",   WBRd,       5'd9);
    #1 chk("tmo_next_stall", Stall, 1'b0);
    tick();
    DMemReady = 1'b0;
    ex(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tmo_next_wbv", WBValid,    1'b1);
    chk("tmo_next_wbd", WBData,     64'h55);
    chk("tmo_next_rd",  WBRd,       5'd4);
    chk("tmo_next_fv",  FaultValid, 1'b0);
    chk("tmo_next_req", DMemReq,    1'b0);

    // MemRead and MemWrite both high behaves as a store
    ex(1'b1, 64'h10, 64'h77, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    ex(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    DMemReady = 1'b1;
    chk("both_req", DMemReq,   1'b1);
    chk("both_we",  DMemWe,    1'b1);
    chk("both_wd",  DMemWData, 64'h77);
    tick();
    DMemReady = 1'b0;
    chk("both_wbv", WBValid, 1'b1);

    // Asynchronous reset in the middle of an access
    ex(1'b1, 64'h300, 64'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    ex(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_req", DMemReq, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_req",  DMemReq,  1'b0);
    chk("mid_rst_addr",  DMemAddr, 64'h0);
    chk("mid_rst_wbd",   WBData,   64'h0);
    chk("mid_rst_wbv",   WBValid,  1'b0);
    chk("mid_rst_stall", Stall,    1'b0);
    tick();
    rst_n = 1'b1;
    DMemReady = 1'b1;
    DMemRData = 64'hCAFE;
    tick();
    chk("post_rst_wbv", WBValid, 1'b0);
    chk("post_rst_req", DMemReq, 1'b0);
    DMemReady = 1'b0;
    ex(1'b1, 64'h99, 64'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("post_rst_stall", Stall, 1'b0);
    tick();
    ex(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_alu_wbv", WBValid, 1'b1);
    chk("post_rst_alu_wbd", WBData,  64'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
